dot_mac: RTL and testbench

Pipelined, streaming dot-product engine that generalises the single-lane multiply-accumulate unit to `LANES` parallel signed multipliers feeding a registered adder tree and one wide accumulator. It sits between the matrix-operand fetch logic and the result write-back path. Each packet is one dot product, with any number of beats terminated by `in_last`. Valid/ready handshakes apply on both sides; there is no separate clear or run control.

---
 rtl/dot_mac_pkg.sv | 24 ++
 rtl/dot_mac_adder_tree.sv | 33 +++
 rtl/dot_mac.sv | 147 ++++++++++++++
 tb/tb_dot_mac.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_mac_pkg.sv
// Shared types and width/limit helpers for the dot_mac streaming dot-product engine.
package dot_mac_pkg;

    localparam int MAX_ACC_W = 128;

    typedef struct packed {
        logic valid;
        logic last;
    } stage_sb_t;

    function automatic int lane_sum_width(input int data_width, input int lanes);
        return 2 * data_width + $clog2(lanes);
    endfunction

    // Limits are returned MAX_ACC_W wide; callers truncate to their accumulator width.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int accum_width);
        return {MAX_ACC_W{1'b1}} >> (MAX_ACC_W - accum_width + 1);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_min(input int accum_width);
        return ~sat_max(accum_width);
    endfunction

endpackage

// File: rtl/dot_mac_adder_tree.sv
// Combinational signed reduction of LANES full-precision products into one ACCUM_WIDTH sum.
module dot_mac_adder_tree
    import dot_mac_pkg::*;
#(
    parameter int PROD_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int ACCUM_WIDTH = 40
) (
    input  logic [LANES*PROD_WIDTH-1:0] prod_i,
    output logic signed [ACCUM_WIDTH-1:0] sum_o
);

    localparam int NPOW = 1 << $clog2(LANES);

    logic signed [ACCUM_WIDTH-1:0] node [NPOW];

    // Leaves padded to a power of two with zeros, then folded pairwise level by level.
    always_comb begin
        for (int i = 0; i < NPOW; i++) begin
            node[i] = '0;
            if (i < LANES) begin
                node[i] = ACCUM_WIDTH'($signed(prod_i[i*PROD_WIDTH +: PROD_WIDTH]));
            end
        end
        for (int w = NPOW / 2; w >= 1; w = w / 2) begin
            for (int j = 0; j < w; j++) begin
                node[j] = node[2*j] + node[2*j+1];
            end
        end
        sum_o = node[0];
    end

endmodule

// File: rtl/dot_mac.sv
// Pipelined streaming dot-product engine: multiply, reduce, accumulate with valid/ready flow.
// Define DOT_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module dot_mac
    import dot_mac_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int LANES       = 4,
    parameter int ACCUM_WIDTH = 2*DATA_WIDTH+8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACCUM_WIDTH-1:0] out_total,
    output logic                          out_err
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int MSB = ACCUM_WIDTH - 1;

    if (LANES < 1) begin : g_bad_lanes
        $error("dot_mac: LANES must be at least 1");
    end
    if (ACCUM_WIDTH < lane_sum_width(DATA_WIDTH, LANES)) begin : g_bad_width
        $error("dot_mac: ACCUM_WIDTH too narrow for the lane sum");
    end

    logic                          adv;
    stage_sb_t                     sb_p1_q, sb_p2_q;
    logic [LANES*PW-1:0]           prod_d, prod_p1_q;
    logic signed [ACCUM_WIDTH-1:0] sum_d, sum_p2_q;
    logic signed [ACCUM_WIDTH-1:0] acc_q, acc_d, next_raw, next_val;
    logic                          err_acc_q, err_acc_d, ovf;
    logic                          out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic signed [ACCUM_WIDTH-1:0] out_total_q, out_total_d;

    assign adv       = !out_valid_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign out_err   = out_err_q;

    // S1: full-precision lane products
    always_comb begin
        prod_d = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_d[i*PW +: PW] = PW'($signed(in_a[i*DATA_WIDTH +: DATA_WIDTH]))
                               * PW'($signed(in_b[i*DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_p1_q <= '0;
            sb_p2_q <= '0;
        end else if (adv) begin
            sb_p1_q <= '{valid: in_valid, last: in_last};
            sb_p2_q <= sb_p1_q;
        end
    end

    // S2: lane reduction
    dot_mac_adder_tree #(
        .PROD_WIDTH (PW),
        .LANES      (LANES),
        .ACCUM_WIDTH(ACCUM_WIDTH)
    ) u_tree (
        .prod_i(prod_p1_q),
        .sum_o (sum_d)
    );

    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            prod_p1_q <= prod_d;
        end
        if (adv && sb_p1_q.valid) begin
            sum_p2_q <= sum_d;
        end
    end

    // S3: accumulate and publish
    assign next_raw = acc_q + sum_p2_q;
    assign ovf      = (acc_q[MSB] == sum_p2_q[MSB]) && (next_raw[MSB] != acc_q[MSB]);

`ifdef DOT_MAC_SATURATE_EN
    localparam logic signed [ACCUM_WIDTH-1:0] SAT_MAX = ACCUM_WIDTH'(sat_max(ACCUM_WIDTH));
    localparam logic signed [ACCUM_WIDTH-1:0] SAT_MIN = ACCUM_WIDTH'(sat_min(ACCUM_WIDTH));

    function automatic logic signed [ACCUM_WIDTH-1:0] saturate(
        input logic signed [ACCUM_WIDTH-1:0] raw,
        input logic                          overflow,
        input logic                          neg
    );
        if (!overflow) return raw;
        return neg ? SAT_MIN : SAT_MAX;
    endfunction

    assign next_val = saturate(next_raw, ovf, acc_q[MSB]);
`else
    assign next_val = next_raw;
`endif

    always_comb begin
        acc_d       = acc_q;
        err_acc_d   = err_acc_q;
        out_total_d = out_total_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (adv && sb_p2_q.valid) begin
            if (sb_p2_q.last) begin
                out_total_d = next_val;
                out_err_d   = err_acc_q | ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                err_acc_d   = 1'b0;
            end else begin
                acc_d     = next_val;
                err_acc_d = err_acc_q | ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            err_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_total_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            err_acc_q   <= err_acc_d;
            out_valid_q <= out_valid_d;
            out_total_q <= out_total_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_dot_mac.sv
// Bench for dot_mac: three instances (default, narrow accumulator, single 8-bit lane) against an arithmetic model.
`timescale 1ns/1ps
module tb_dot_mac;

    localparam int DW = 16, LN = 4, AW0 = 40, AW1 = 34, DW2 = 8, AW2 = 24;

`ifdef DOT_MAC_SATURATE_EN
    localparam longint OVF_EXP = 64'sd8589934591;
`else
    localparam longint OVF_EXP = -64'sd8589934592;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst, vin, last_in, ordy, v2, last2, ordy2;
    logic [LN*DW-1:0]      a_in, b_in;
    logic [DW2-1:0]        a2, b2;
    logic                  rdy0, rdy1, rdy2, ov0, ov1, ov2, err0, err1, err2;
    logic signed [AW0-1:0] tot0;
    logic signed [AW1-1:0] tot1;
    logic signed [AW2-1:0] tot2;

    dot_mac #(.DATA_WIDTH(DW), .LANES(LN)) dut0 (
        .clk(clk), .rst(rst), .in_valid(vin), .in_ready(rdy0), .in_a(a_in), .in_b(b_in),
        .in_last(last_in), .out_valid(ov0), .out_ready(ordy), .out_total(tot0), .out_err(err0));

    dot_mac #(.DATA_WIDTH(DW), .LANES(LN), .ACCUM_WIDTH(AW1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(vin), .in_ready(rdy1), .in_a(a_in), .in_b(b_in),
        .in_last(last_in), .out_valid(ov1), .out_ready(ordy), .out_total(tot1), .out_err(err1));

    dot_mac #(.DATA_WIDTH(DW2), .LANES(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_a(a2), .in_b(b2),
        .in_last(last2), .out_valid(ov2), .out_ready(ordy2), .out_total(tot2), .out_err(err2));

    int     n_assert = 0, n_fail = 0, npop0 = 0, n_stall = 0;
    bit     accepted, rand_ordy = 1'b0, stall_release = 1'b0;
    longint m_acc [3];
    bit     m_err [3];
    longint q_tot [3][$];
    bit     q_err [3][$];

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Exact integer sum, then range test against the accumulator limits.
    function automatic void acc_step(input longint acc_in, input longint s, input int aw,
                                     output longint acc_out, output bit ovf);
        longint mx, mn, ex;
        mx  = (longint'(1) <<< (aw - 1)) - 1;
        mn  = -mx - 1;
        ex  = acc_in + s;
        ovf = (ex > mx) || (ex < mn);
`ifdef DOT_MAC_SATURATE_EN
        acc_out = (ex > mx) ? mx : ((ex < mn) ? mn : ex);
`else
        acc_out = (ex > mx) ? ex - 2 * (mx + 1) : ((ex < mn) ? ex + 2 * (mx + 1) : ex);
`endif
    endfunction

    function automatic longint beat_sum(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b);
        longint s = 0;
        for (int i = 0; i < LN; i++)
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        return s;
    endfunction

    task automatic model_beat(input int ch, input longint s, input int aw, input bit last);
        longint na;
        bit     ov;
        acc_step(m_acc[ch], s, aw, na, ov);
        m_err[ch] = m_err[ch] | ov;
        if (last) begin
            q_tot[ch].push_back(na);
            q_err[ch].push_back(m_err[ch]);
            m_acc[ch] = 0;
            m_err[ch] = 1'b0;
        end else begin
            m_acc[ch] = na;
        end
    endtask

    task automatic pop_check(input int ch, input logic signed [63:0] tot, input logic err);
        check($sformatf("ch%0d_result_expected", ch), q_tot[ch].size() != 0, 1);
        if (q_tot[ch].size() != 0) begin
            check($sformatf("ch%0d_total", ch), tot, q_tot[ch].pop_front());
            check($sformatf("ch%0d_err", ch), err, q_err[ch].pop_front());
        end
    endtask

    // One clock: observe handshakes at mid-cycle, update the model, advance to the next negedge.
    task automatic cycle();
        #1;
        accepted = 1'b0;
        if (rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                m_acc[ch] = 0;
                m_err[ch] = 1'b0;
                q_tot[ch].delete();
                q_err[ch].delete();
            end
        end else begin
            if (ov0 && ordy) begin
                pop_check(0, tot0, err0);
                npop0++;
            end
            if (ov1 && ordy)  pop_check(1, tot1, err1);
            if (ov2 && ordy2) pop_check(2, tot2, err2);
            if (vin && !rdy0) n_stall++;
            if (vin && rdy0) begin
                accepted = 1'b1;
                model_beat(0, beat_sum(a_in, b_in), AW0, last_in);
            end
            if (vin && rdy1) model_beat(1, beat_sum(a_in, b_in), AW1, last_in);
            if (v2 && rdy2)  model_beat(2, longint'($signed(a2)) * longint'($signed(b2)), AW2, last2);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_beat(input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b, input logic last);
        int g = 0;
        vin = 1'b1; a_in = a; b_in = b; last_in = last;
        do begin
            if (rand_ordy) ordy = ($urandom_range(0, 3) != 0);
            cycle();
            g++;
            if (stall_release && n_stall >= 5) ordy = 1'b1;
        end while (!accepted && g < 50);
        check("beat_accepted", accepted, 1);
        vin = 1'b0;
    endtask

    task automatic wait_valid(input int ch, output int lat);
        lat = 0;
        while (!((ch == 0) ? ov0 : (ch == 1) ? ov1 : ov2) && lat < 20) begin
            cycle();
            lat++;
        end
    endtask

    task automatic drain();
        vin = 1'b0; v2 = 1'b0; ordy = 1'b1; ordy2 = 1'b1;
        repeat (8) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, pops_before;
        rst = 1'b1; vin = 1'b0; last_in = 1'b0; a_in = '0; b_in = '0; ordy = 1'b1;
        v2 = 1'b0; last2 = 1'b0; a2 = '0; b2 = '0; ordy2 = 1'b1;
        cycle(); cycle();
        check("rst_out_valid", ov0, 0);
        check("rst_out_total", tot0, 0);
        check("rst_out_err", err0, 0);
        check("rst_in_ready", rdy0, 1);
        check("rst_out_valid_narrow", ov1, 0);
        check("rst_out_valid_lane1", ov2, 0);
        rst = 1'b0;
        cycle();

        // Single beat {1,2,3,4}.{5,6,7,8} and its latency
        send_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1);
        wait_valid(0, lat);
        check("latency_cycles", lat + 1, 3);
        check("one_beat_total", tot0, 70);
        check("one_beat_err", err0, 0);
        drain();

        // Three-beat packet then a one-beat packet, back to back
        for (int k = 0; k < 3; k++) send_beat({4{16'hFFFD}}, {4{16'd7}}, k == 2);
        send_beat({4{16'd1}}, {4{16'd1}}, 1'b1);
        wait_valid(0, lat);
        check("b2b_first_total", tot0, -252);
        cycle();
        check("b2b_second_valid", ov0, 1);
        check("b2b_second_total", tot0, 4);
        drain();

        // Output held for five stalled cycles while four packets stream
        n_stall = 0; pops_before = npop0; ordy = 1'b0; stall_release = 1'b1;
        for (int p = 0; p < 4; p++) begin
            int nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++)
                send_beat({$urandom, $urandom}, {$urandom, $urandom}, k == nb - 1);
        end
        stall_release = 1'b0;
        drain();
        check("stall_cycles", n_stall, 5);
        check("stall_results", npop0 - pops_before, 4);

        // Overflow in the narrow accumulator, then a clean packet
        for (int k = 0; k < 2; k++) send_beat({4{16'h8000}}, {4{16'h8000}}, k == 1);
        send_beat({4{16'd1}}, {4{16'd1}}, 1'b1);
        wait_valid(1, lat);
        check("ovf_total", tot1, OVF_EXP);
        check("ovf_err", err1, 1);
        check("wide_no_ovf_total", tot0, 64'sd8589934592);
        check("wide_no_ovf_err", err0, 0);
        cycle();
        check("after_ovf_total", tot1, 4);
        check("after_ovf_err", err1, 0);
        drain();

        // Reset after two of four beats
        for (int k = 0; k < 2; k++) send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_out_valid", ov0, 0);
        check("midrst_out_total", tot0, 0);
        send_beat({4{16'd2}}, {4{16'd2}}, 1'b1);
        wait_valid(0, lat);
        check("midrst_fresh_total", tot0, 16);
        check("midrst_fresh_err", err0, 0);
        check("midrst_fresh_total_narrow", tot1, 16);
        drain();

        // Single 8-bit lane, most negative operands
        v2 = 1'b1; a2 = 8'h80; b2 = 8'h80; last2 = 1'b1;
        cycle();
        v2 = 1'b0;
        wait_valid(2, lat);
        check("lane1_total", tot2, 16384);
        check("lane1_err", err2, 0);
        drain();

        // Random packets with random back-pressure and bubbles
        rand_ordy = 1'b1;
        for (int p = 0; p < 25; p++) begin
            int nb = $urandom_range(1, 4);
            for (int k = 0; k < nb; k++) begin
                send_beat({$urandom, $urandom}, {$urandom, $urandom}, k == nb - 1);
                if ($urandom_range(0, 3) == 0) begin
                    ordy = ($urandom_range(0, 3) != 0);
                    cycle();
                end
            end
        end
        rand_ordy = 1'b0;
        drain();
        check("queue_empty_wide", q_tot[0].size(), 0);
        check("queue_empty_narrow", q_tot[1].size(), 0);
        check("queue_empty_lane1", q_tot[2].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
